// File: rtl/vmax_pkg.sv
// ---------------------------------------------------------------------------
// vmax_pkg
// Shared types and constants for the vertical max-pool sequencer.
//   state_t : sequencer FSM states (IDLE, RUN, DRAIN)
//   row_t   : one row of SA_LENGTH signed lanes at the default sizes
//   FS_W    : width of the filter_size / stride configuration fields
// ---------------------------------------------------------------------------
package vmax_pkg;

    localparam int DEF_DATA_WIDTH      = 32;
    localparam int DEF_SA_LENGTH       = 10;
    localparam int DEF_MAX_FILTER_SIZE = 7;
    localparam int DEF_ROW_CNT_WIDTH   = 16;

    localparam int FS_W = $clog2(DEF_MAX_FILTER_SIZE + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef logic signed [DEF_DATA_WIDTH-1:0] row_t [DEF_SA_LENGTH];

endpackage

// File: rtl/vmax_window_reduce.sv
// ---------------------------------------------------------------------------
// vmax_window_reduce
// Combinational per-lane signed maximum over the incoming row and the first
// K-1 rows of the line buffer. Buffer rows at index K-1 and beyond are masked
// out at run time, so K=1 passes the incoming row straight through.
// Ports:
//   i_row : current row (SA_LENGTH lanes)
//   i_buf : line buffer, i_buf[0] is the most recent previously accepted row
//   i_k   : window height K
//   o_max : per-lane signed maximum of the window
// ---------------------------------------------------------------------------
module vmax_window_reduce #(
    parameter int DATA_WIDTH = 32,
    parameter int SA_LENGTH  = 10,
    parameter int DEPTH      = 6,
    parameter int KW         = 3
) (
    input  logic signed [DATA_WIDTH-1:0] i_row [SA_LENGTH],
    input  logic signed [DATA_WIDTH-1:0] i_buf [DEPTH][SA_LENGTH],
    input  logic        [KW-1:0]         i_k,
    output logic signed [DATA_WIDTH-1:0] o_max [SA_LENGTH]
);

    genvar gi;
    generate
        for (gi = 0; gi < SA_LENGTH; gi++) begin : g_lane
            logic signed [DATA_WIDTH-1:0] w_lane_max;

            always_comb begin
                w_lane_max = i_row[gi];
                for (int j = 0; j < DEPTH; j++) begin
                    // Buffer row j belongs to the window only when j < K-1.
                    if (((j + 1) < int'(i_k)) && (i_buf[j][gi] > w_lane_max)) begin
                        w_lane_max = i_buf[j][gi];
                    end
                end
            end

            assign o_max[gi] = w_lane_max;
        end
    endgenerate

endmodule

// File: rtl/vmax_pool_sequencer.sv
// ---------------------------------------------------------------------------
// vmax_pool_sequencer
// Vertical max-pooling over a stream of horizontal-max rows. Keeps the last
// K-1 rows in a line buffer, tracks the row index against the stride and
// emits one pooled row per complete vertical window (floor mode), then
// pulses done.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   start                 : begin a pass (sampled in IDLE only)
//   filter_size/stride    : window height K, vertical stride S
//   num_rows              : input feature height H
//   in_valid/in_ready     : HMax row handshake
//   HMax                  : input row
//   out_valid/out_ready   : pooled row handshake
//   VMax                  : pooled row, held stable while out_valid && !out_ready
//   busy                  : pass in progress (RUN or DRAIN)
//   done                  : one-cycle pulse at end of pass
//   cfg_err               : one-cycle pulse when a start is rejected
// ---------------------------------------------------------------------------
module vmax_pool_sequencer
    import vmax_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int SA_LENGTH       = 10,
    parameter int MAX_FILTER_SIZE = 7,
    parameter int ROW_CNT_WIDTH   = 16,
    localparam int KW             = $clog2(MAX_FILTER_SIZE + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic        [KW-1:0]         filter_size,
    input  logic        [KW-1:0]         stride,
    input  logic        [ROW_CNT_WIDTH-1:0] num_rows,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] HMax [SA_LENGTH],
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] VMax [SA_LENGTH],
    output logic                         busy,
    output logic                         done,
    output logic                         cfg_err
);

    localparam int DEPTH = MAX_FILTER_SIZE - 1;
    // One extra bit so next_emit can step past H without wrapping.
    localparam int NW = ROW_CNT_WIDTH + 1;
    localparam logic [KW-1:0] MAX_FS = KW'(MAX_FILTER_SIZE);

    state_t                       r_state;
    logic        [KW-1:0]         r_k;
    logic        [KW-1:0]         r_s;
    logic        [ROW_CNT_WIDTH-1:0] r_h;
    logic        [ROW_CNT_WIDTH-1:0] r_row_idx;
    logic        [NW-1:0]         r_next_emit;
    logic signed [DATA_WIDTH-1:0] r_buf  [DEPTH][SA_LENGTH];
    logic signed [DATA_WIDTH-1:0] r_vmax [SA_LENGTH];
    logic                         r_out_valid;
    logic                         r_done;
    logic                         r_cfg_err;

    logic                         w_accept;
    logic                         w_emit;
    logic                         w_last;
    logic                         w_cfg_ok;
    logic signed [DATA_WIDTH-1:0] w_max [SA_LENGTH];

    assign in_ready = (r_state == RUN) && (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready;
    assign w_emit   = (NW'(r_row_idx) == r_next_emit);
    assign w_last   = (r_row_idx == (r_h - ROW_CNT_WIDTH'(1)));
    assign w_cfg_ok = (filter_size != '0) && (filter_size <= MAX_FS) &&
                      (stride != '0) && (stride <= MAX_FS) &&
                      (num_rows >= ROW_CNT_WIDTH'(filter_size));

    vmax_window_reduce #(
        .DATA_WIDTH (DATA_WIDTH),
        .SA_LENGTH  (SA_LENGTH),
        .DEPTH      (DEPTH),
        .KW         (KW)
    ) u_reduce (
        .i_row (HMax),
        .i_buf (r_buf),
        .i_k   (r_k),
        .o_max (w_max)
    );

    // Line buffer: newest accepted row enters at index 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < DEPTH; d++) begin
                for (int l = 0; l < SA_LENGTH; l++) begin
                    r_buf[d][l] <= '0;
                end
            end
        end else if (w_accept) begin
            r_buf[0] <= HMax;
            for (int d = 1; d < DEPTH; d++) begin
                r_buf[d] <= r_buf[d-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_k         <= '0;
            r_s         <= '0;
            r_h         <= '0;
            r_row_idx   <= '0;
            r_next_emit <= '0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            r_cfg_err   <= 1'b0;
            for (int l = 0; l < SA_LENGTH; l++) begin
                r_vmax[l] <= '0;
            end
        end else begin
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (w_cfg_ok) begin
                            r_k         <= filter_size;
                            r_s         <= stride;
                            r_h         <= num_rows;
                            r_row_idx   <= '0;
                            r_next_emit <= NW'(filter_size) - NW'(1);
                            r_state     <= RUN;
                        end else begin
                            r_cfg_err <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (w_accept) begin
                        r_row_idx <= r_row_idx + ROW_CNT_WIDTH'(1);
                        if (w_emit) begin
                            // Replaces any row being consumed this cycle: no bubble.
                            r_out_valid <= 1'b1;
                            r_vmax      <= w_max;
                            r_next_emit <= r_next_emit + NW'(r_s);
                        end else if (out_ready) begin
                            r_out_valid <= 1'b0;
                        end
                        if (w_last) begin
                            r_state <= DRAIN;
                        end
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (!r_out_valid || out_ready) begin
                        r_out_valid <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign VMax      = r_vmax;
    assign busy      = (r_state != IDLE);
    assign done      = r_done;
    assign cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_vmax_pool_sequencer.sv
// ---------------------------------------------------------------------------
// tb_vmax_pool_sequencer
// Directed bench for the vertical max-pool sequencer. Each input row carries
// value v in lanes 0..8 as v+lane and -v in lane 9, so a window's expected
// output is (max v)+lane in lanes 0..8 and -(min v) in lane 9. Expected rows
// are queued when a pass is issued; a monitor pops and compares on every
// output handshake.
// ---------------------------------------------------------------------------
module tb_vmax_pool_sequencer;
    import vmax_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start;
    logic [FS_W-1:0]  filter_size;
    logic [FS_W-1:0]  stride;
    logic [15:0]      num_rows;
    logic             in_valid;
    logic             in_ready;
    row_t             hmax;
    logic             out_valid;
    logic             out_ready;
    row_t             vmax;
    logic             busy;
    logic             done;
    logic             cfg_err;

    typedef struct {
        int e0;
        int e9;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   out_cnt = 0;
    int   last_hs_cyc = 0;
    int   last_done_cyc = 0;

    vmax_pool_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .filter_size (filter_size),
        .stride      (stride),
        .num_rows    (num_rows),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .HMax        (hmax),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .VMax        (vmax),
        .busy        (busy),
        .done        (done),
        .cfg_err     (cfg_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                done_cnt++;
                last_done_cyc = cyc;
                $display("done at cycle %0d", cyc);
            end
            if (out_valid && out_ready) begin
                last_hs_cyc = cyc;
                out_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output actual lane0=%0d required none", vmax[0]);
                end else begin
                    bit ok;
                    e  = exp_q.pop_front();
                    ok = 1'b1;
                    for (int l = 0; l < 9; l++) begin
                        if (vmax[l] != e.e0 + l) ok = 1'b0;
                    end
                    if (vmax[9] != e.e9) ok = 1'b0;
                    if (!ok) begin
                        errors++;
                        $display("FAIL output_row actual lane0=%0d lane1=%0d lane9=%0d required lane0=%0d lane1=%0d lane9=%0d",
                                 vmax[0], vmax[1], vmax[9], e.e0, e.e0 + 1, e.e9);
                    end else begin
                        $display("out row lane0=%0d lane9=%0d", vmax[0], vmax[9]);
                    end
                end
            end
        end
    end

    task automatic push_exp(input int e0, input int e9);
        exp_t x;
        x.e0 = e0;
        x.e9 = e9;
        exp_q.push_back(x);
    endtask

    task automatic set_row(input int v);
        for (int l = 0; l < 9; l++) hmax[l] = v + l;
        hmax[9] = -v;
    endtask

    task automatic send_row(input int v);
        bit got;
        set_row(v);
        in_valid = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
        end
        if (!got) begin
            chk("in_ready_timeout", 0, 1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        $display("in row v=%0d", v);
    endtask

    task automatic start_pass(input int k, input int s, input int h);
        @(posedge clk);
        #1;
        start       = 1'b1;
        filter_size = FS_W'(k);
        stride      = FS_W'(s);
        num_rows    = 16'(h);
        @(posedge clk);
        #1;
        start = 1'b0;
        $display("start K=%0d S=%0d H=%0d", k, s, h);
    endtask

    task automatic wait_done(input int prev);
        for (int n = 0; n < 100 && done_cnt == prev; n++) @(negedge clk);
        chk("done_seen", done_cnt, prev + 1);
        @(posedge clk);
        #1;
        chk("busy_after_done", busy, 0);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    task automatic bad_start(input int k, input int s, input int h);
        start_pass(k, s, h);
        chk("cfg_err_pulse", cfg_err, 1);
        chk("busy_after_bad_start", busy, 0);
        @(posedge clk);
        #1;
        chk("cfg_err_clears", cfg_err, 0);
    endtask

    task automatic run_scenario1();
        int d0;
        d0 = done_cnt;
        push_exp(905, -642);
        push_exp(834, -248);
        start_pass(2, 2, 4);
        chk("s1_busy_run", busy, 1);
        send_row(642);
        send_row(905);
        send_row(248);
        send_row(834);
        wait_done(d0);
        chk("s1_done_latency", last_done_cyc, last_hs_cyc + 1);
    endtask

    initial begin
        int d0;
        int oc0;
        start       = 1'b0;
        filter_size = '0;
        stride      = '0;
        num_rows    = '0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        set_row(0);

        #2 rst = 1'b1;
        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_vmax0", vmax[0], 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Scenario 1: K=2 S=2 H=4
        run_scenario1();

        // Scenario 2: signed, overlapping windows, start during RUN ignored
        d0 = done_cnt;
        push_exp(-1, 9);
        push_exp(-1, 9);
        push_exp(-2, 9);
        start_pass(3, 1, 5);
        send_row(-5);
        start_pass(1, 1, 1);
        chk("s2_run_start_no_cfg_err", cfg_err, 0);
        chk("s2_run_start_busy", busy, 1);
        send_row(-1);
        send_row(-9);
        send_row(-2);
        send_row(-7);
        wait_done(d0);

        // Scenario 3: K=3 S=2 H=6, trailing row discarded
        d0  = done_cnt;
        oc0 = out_cnt;
        push_exp(30, -10);
        push_exp(20, 40);
        start_pass(3, 2, 6);
        send_row(10);
        send_row(30);
        send_row(20);
        send_row(-40);
        send_row(5);
        send_row(99);
        wait_done(d0);
        chk("s3_output_count", out_cnt - oc0, 2);

        // Scenario 4: backpressure on the first output
        d0  = done_cnt;
        oc0 = out_cnt;
        push_exp(7, -1);
        push_exp(7, -3);
        push_exp(3, -3);
        out_ready = 1'b0;
        start_pass(2, 1, 4);
        send_row(1);
        send_row(7);
        set_row(3);
        in_valid = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk("s4_hold_in_ready", in_ready, 0);
            chk("s4_hold_out_valid", out_valid, 1);
            chk("s4_hold_vmax0", vmax[0], 7);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        send_row(3);
        send_row(3);
        wait_done(d0);
        chk("s4_output_count", out_cnt - oc0, 3);

        // K=1 pass-through with stride 3
        d0 = done_cnt;
        push_exp(4, -4);
        push_exp(2, -2);
        push_exp(9, -9);
        start_pass(1, 3, 7);
        send_row(4);
        send_row(-8);
        send_row(6);
        send_row(2);
        send_row(-1);
        send_row(0);
        send_row(9);
        wait_done(d0);

        // Scenario 5: rejected configurations
        bad_start(0, 1, 4);
        bad_start(3, 0, 4);
        bad_start(3, 1, 2);

        // Scenario 6: reset in the middle of scenario 1
        push_exp(905, -642);
        push_exp(834, -248);
        out_ready = 1'b0;
        start_pass(2, 2, 4);
        send_row(642);
        send_row(905);
        d0 = done_cnt;
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("s6_rst_out_valid", out_valid, 0);
        chk("s6_rst_busy", busy, 0);
        chk("s6_rst_in_ready", in_ready, 0);
        chk("s6_rst_vmax0", vmax[0], 0);
        chk("s6_rst_vmax9", vmax[9], 0);
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("s6_no_done_after_abort", done_cnt, d0);
        run_scenario1();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
